// File: rtl/muldiv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// muldiv_pkg : op encodings, sequencer states and HI/LO width
// Rev 1.0
// ------------------------------------------------------------------
package muldiv_pkg;

  localparam int HILO_W = 64;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_DONE     = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// hilo_reg : architectural HI/LO pair, independent write enables
// Rev 1.0
// ------------------------------------------------------------------
module hilo_reg
  import muldiv_pkg::*;
(
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [HILO_W-1:0] wdata_i,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o
);

  logic [31:0] hi_q;
  logic [31:0] lo_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we_i) hi_q <= wdata_i[HILO_W-1:32];
      if (lo_we_i) lo_q <= wdata_i[31:0];
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_hilo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// muldiv_hilo_ctrl : EX-stage mult/div sequencer, stall source, HI/LO owner
// Rev 1.0
// ------------------------------------------------------------------
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_TMO = 40
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              op_valid_i,
  input  logic [2:0]        op_i,
  input  logic [31:0]       src_a_i,
  input  logic [31:0]       src_b_i,
  input  logic              flush_i,
  input  logic              ex_hold_i,
  output logic              stallreq_o,
  output logic              mul_signed_o,
  output logic [31:0]       mul_opa_o,
  output logic [31:0]       mul_opb_o,
  input  logic [HILO_W-1:0] mul_result_i,
  output logic              div_start_o,
  output logic              div_signed_o,
  output logic [31:0]       div_opa_o,
  output logic [31:0]       div_opb_o,
  output logic              div_annul_o,
  input  logic              div_ready_i,
  input  logic [HILO_W-1:0] div_result_i,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam int WD_W  = $clog2(DIV_TMO + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [WD_W-1:0]   wdog_q;
  logic [31:0]       mul_opa_q, mul_opb_q, div_opa_q, div_opb_q;
  logic              mul_signed_q, div_signed_q;

  logic              is_mul, is_div;
  logic              launch_mul, launch_div;
  logic              mul_done, div_done, div_tmo;
  logic              hi_we, lo_we;
  logic [HILO_W-1:0] hilo_wdata;

  assign is_mul     = op_valid_i && (op_i == OP_MULT || op_i == OP_MULTU);
  assign is_div     = op_valid_i && (op_i == OP_DIV  || op_i == OP_DIVU);
  assign launch_mul = (state_q == S_IDLE) && is_mul && !flush_i;
  assign launch_div = (state_q == S_IDLE) && is_div && !flush_i;
  assign mul_done   = (state_q == S_MUL_WAIT) && (cnt_q == '0) && !flush_i;
  assign div_done   = (state_q == S_DIV_RUN) && div_ready_i && !flush_i;
  // A result arriving on the last allowed cycle still wins over the watchdog.
  assign div_tmo    = (state_q == S_DIV_RUN) && !div_ready_i &&
                      (wdog_q == WD_W'(DIV_TMO - 1));

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (launch_mul)      state_d = S_MUL_WAIT;
        else if (launch_div) state_d = S_DIV_RUN;
      end
      S_MUL_WAIT: begin
        if (cnt_q == '0) state_d = ex_hold_i ? S_DONE : S_IDLE;
      end
      S_DIV_RUN: begin
        if (div_ready_i)  state_d = ex_hold_i ? S_DONE : S_IDLE;
        else if (div_tmo) state_d = S_IDLE;
      end
      S_DONE: begin
        if (!ex_hold_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_comb begin
    stallreq_o  = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    hilo_wdata  = {src_a_i, src_a_i};
    case (state_q)
      S_IDLE: begin
        stallreq_o = launch_mul || launch_div;
        if (op_valid_i && !flush_i && !ex_hold_i) begin
          hi_we = (op_i == OP_MTHI);
          lo_we = (op_i == OP_MTLO);
        end
      end
      S_MUL_WAIT: begin
        stallreq_o = !flush_i && (cnt_q != '0);
        if (mul_done) begin
          hi_we      = 1'b1;
          lo_we      = 1'b1;
          hilo_wdata = mul_result_i;
        end
      end
      S_DIV_RUN: begin
        stallreq_o  = !flush_i && !div_ready_i && !div_tmo;
        div_start_o = !flush_i && !div_ready_i && !div_tmo;
        div_annul_o = flush_i || div_tmo;
        if (div_done) begin
          hi_we      = 1'b1;
          lo_we      = 1'b1;
          hilo_wdata = div_result_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q        <= '0;
      wdog_q       <= '0;
      mul_opa_q    <= '0;
      mul_opb_q    <= '0;
      mul_signed_q <= 1'b0;
      div_opa_q    <= '0;
      div_opb_q    <= '0;
      div_signed_q <= 1'b0;
    end else begin
      if (launch_mul) begin
        mul_opa_q    <= src_a_i;
        mul_opb_q    <= src_b_i;
        mul_signed_q <= (op_i == OP_MULT);
        cnt_q        <= CNT_W'(MUL_LAT - 1);
      end else if (state_q == S_MUL_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (launch_div) begin
        div_opa_q    <= src_a_i;
        div_opb_q    <= src_b_i;
        div_signed_q <= (op_i == OP_DIV);
        wdog_q       <= '0;
      end else if (state_q == S_DIV_RUN) begin
        wdog_q <= wdog_q + WD_W'(1);
      end
    end
  end

  assign mul_signed_o = mul_signed_q;
  assign mul_opa_o    = mul_opa_q;
  assign mul_opb_o    = mul_opb_q;
  assign div_signed_o = div_signed_q;
  assign div_opa_o    = div_opa_q;
  assign div_opb_o    = div_opb_q;

  hilo_reg u_hilo (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .hi_we_i  (hi_we),
    .lo_we_i  (lo_we),
    .wdata_i  (hilo_wdata),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_muldiv_hilo_ctrl : scenario tasks plus randomized ops vs arithmetic model
// Rev 1.0
// ------------------------------------------------------------------
module tb_muldiv_hilo_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_TMO = 40;
  localparam int MAXW    = 200;

  logic        clk = 1'b0;
  logic        resetn, op_valid, flush, ex_hold;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, mul_signed, div_start, div_signed, div_annul, div_ready;
  logic [31:0] mul_opa, mul_opb, div_opa, div_opb, hi, lo;
  logic [63:0] mul_result, div_result;

  int          checks = 0;
  int          errors = 0;
  int          div_lat = 33;
  int          dcnt;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        cap_mul_signed, cap_div_signed, cap_div_start;
  logic [31:0] cap_opa, cap_opb;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT), .DIV_TMO(DIV_TMO)) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .op_valid_i   (op_valid),
    .op_i         (op),
    .src_a_i      (src_a),
    .src_b_i      (src_b),
    .flush_i      (flush),
    .ex_hold_i    (ex_hold),
    .stallreq_o   (stallreq),
    .mul_signed_o (mul_signed),
    .mul_opa_o    (mul_opa),
    .mul_opb_o    (mul_opb),
    .mul_result_i (mul_result),
    .div_start_o  (div_start),
    .div_signed_o (div_signed),
    .div_opa_o    (div_opa),
    .div_opb_o    (div_opb),
    .div_annul_o  (div_annul),
    .div_ready_i  (div_ready),
    .div_result_i (div_result),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  // Architectural {HI,LO} result of a mult/div; a zero divisor yields {dividend, all-ones}.
  function automatic logic [63:0] ref_hilo(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  r = 64'(sa * sb);
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  always_comb mul_result = ref_hilo(mul_signed ? OP_MULT : OP_MULTU, mul_opa, mul_opb);

  // Divider stand-in: ready one cycle after div_lat consecutive cycles of div_start.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dcnt       <= 0;
      div_ready  <= 1'b0;
      div_result <= '0;
    end else begin
      div_ready <= 1'b0;
      if (div_annul || !div_start) dcnt <= 0;
      else if (dcnt >= div_lat - 1) begin
        div_ready  <= 1'b1;
        div_result <= ref_hilo(div_signed ? OP_DIV : OP_DIVU, div_opa, div_opb);
        dcnt       <= 0;
      end else dcnt <= dcnt + 1;
    end
  end

  // Present one op until the cycle stallreq drops, let it retire, then remove it.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    stalls = 0;
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cap_mul_signed = mul_signed;
        cap_div_signed = div_signed;
        cap_div_start  = div_start;
        cap_opa        = (o == OP_DIV || o == OP_DIVU) ? div_opa : mul_opa;
        cap_opb        = (o == OP_DIV || o == OP_DIVU) ? div_opb : mul_opb;
      end
      if (!stallreq) break;
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd7;
  endtask

  task automatic test_reset();
    resetn = 1'b0; op_valid = 1'b0; op = 3'd7; src_a = '0; src_b = '0;
    flush = 1'b0; ex_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hi, lo} !== 64'd0) begin
      errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    checks++;
    if ({stallreq, div_start, div_annul, mul_signed, div_signed} !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {stallreq, div_start, div_annul, mul_signed, div_signed});
    end
    checks++;
    if ({mul_opa, mul_opb, div_opa, div_opb} !== 128'd0) begin
      errors++; $display("FAIL reset_launch_regs: got %h expected 0", {mul_opa, mul_opb, div_opa, div_opb});
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int st;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, st);
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
    checks++;
    if (st !== 2) begin errors++; $display("FAIL mult_stall_cycles: got %0d expected 2", st); end
    checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++; $display("FAIL mult_hilo: got %h expected %h", {hi, lo}, {exp_hi, exp_lo});
    end
    checks++;
    if (cap_mul_signed !== 1'b1) begin errors++; $display("FAIL mult_signed: got %b expected 1", cap_mul_signed); end
  endtask

  task automatic test_divu();
    int st;
    div_lat = 33;
    issue(OP_DIVU, 32'd100, 32'd7, st);
    exp_hi = 32'd2; exp_lo = 32'd14;
    checks++;
    if (st !== 34) begin errors++; $display("FAIL divu_stall_cycles: got %0d expected 34", st); end
    checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++; $display("FAIL divu_hilo: got %h expected %h", {hi, lo}, {exp_hi, exp_lo});
    end
    checks++;
    if ({cap_div_signed, cap_div_start} !== 2'b01) begin
      errors++; $display("FAIL divu_sign_start: got %b expected 01", {cap_div_signed, cap_div_start});
    end
    @(negedge clk);
    checks++;
    if ({div_start, stallreq} !== 2'b00) begin
      errors++; $display("FAIL divu_no_relaunch: got %b expected 00", {div_start, stallreq});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    div_lat = 33;
    op_valid = 1'b1; op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({div_annul, stallreq} !== 2'b10) begin
      errors++; $display("FAIL flush_div_annul: got %b expected 10", {div_annul, stallreq});
    end
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({div_annul, div_start, stallreq} !== 3'b000) begin
      errors++; $display("FAIL flush_div_idle: got %b expected 000", {div_annul, div_start, stallreq});
    end
    repeat (40) begin @(posedge clk); #1; end
    checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++; $display("FAIL flush_div_hilo: got %h expected %h", {hi, lo}, {exp_hi, exp_lo});
    end
    // Flush on the multiplier's completion cycle must suppress the write.
    op_valid = 1'b1; op = OP_MULTU; src_a = 32'd9; src_b = 32'd9;
    repeat (MUL_LAT) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (stallreq !== 1'b0) begin errors++; $display("FAIL flush_mul_stall: got %b expected 0", stallreq); end
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++; $display("FAIL flush_mul_hilo: got %h expected %h", {hi, lo}, {exp_hi, exp_lo});
    end
  endtask

  task automatic test_mthi_mtlo();
    logic seen;
    seen = 1'b0;
    op_valid = 1'b1; op = OP_MTHI; src_a = 32'h1234;
    @(negedge clk); seen |= stallreq;
    @(posedge clk); #1;
    op = OP_MTLO; src_a = 32'hABCD;
    @(negedge clk); seen |= stallreq;
    @(posedge clk); #1;
    // Held or flushed moves must not write.
    op = OP_MTHI; src_a = 32'hDEAD_0001; ex_hold = 1'b1;
    @(negedge clk); seen |= stallreq;
    @(posedge clk); #1;
    op = OP_MTLO; src_a = 32'hDEAD_0002; ex_hold = 1'b0; flush = 1'b1;
    @(negedge clk); seen |= stallreq;
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    exp_hi = 32'h1234; exp_lo = 32'hABCD;
    checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++; $display("FAIL mt_hilo: got %h expected %h", {hi, lo}, {exp_hi, exp_lo});
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mt_stall: got %b expected 0", seen); end
  endtask

  task automatic test_done_hold();
    logic [63:0] e;
    int st;
    e = ref_hilo(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    div_lat = 5; ex_hold = 1'b1;
    op_valid = 1'b1; op = OP_DIV; src_a = 32'hFFFF_FF9C; src_b = 32'd7;
    st = 0;
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      if (!stallreq) break;
      st++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (st !== 6) begin errors++; $display("FAIL hold_stall_cycles: got %0d expected 6", st); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({stallreq, div_start} !== 2'b00) begin
        errors++; $display("FAIL hold_done_ctrl: got %b expected 00", {stallreq, div_start});
      end
      checks++;
      if ({hi, lo} !== e) begin errors++; $display("FAIL hold_done_hilo: got %h expected %h", {hi, lo}, e); end
      @(posedge clk); #1;
    end
    ex_hold = 1'b0;
    @(negedge clk);
    checks++;
    if ({stallreq, div_start} !== 2'b00) begin
      errors++; $display("FAIL hold_release: got %b expected 00", {stallreq, div_start});
    end
    @(posedge clk); #1;
    op = OP_MTLO; src_a = 32'h5A5A_0001;
    @(posedge clk); #1;
    op_valid = 1'b0;
    exp_hi = e[63:32]; exp_lo = 32'h5A5A_0001;
    checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++; $display("FAIL hold_back_to_idle: got %h expected %h", {hi, lo}, {exp_hi, exp_lo});
    end
  endtask

  task automatic test_watchdog();
    int found;
    found = -1;
    div_lat = 1000;
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd77; src_b = 32'd5;
    for (int i = 0; i < DIV_TMO + 10; i++) begin
      @(negedge clk);
      if (div_annul) begin found = i; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++;
    if (found !== DIV_TMO) begin errors++; $display("FAIL wdog_annul_cycle: got %0d expected %0d", found, DIV_TMO); end
    @(negedge clk);
    checks++;
    if ({div_annul, div_start, stallreq} !== 3'b000) begin
      errors++; $display("FAIL wdog_idle: got %b expected 000", {div_annul, div_start, stallreq});
    end
    checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++; $display("FAIL wdog_hilo: got %h expected %h", {hi, lo}, {exp_hi, exp_lo});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    int st;
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd5; src_b = 32'd6;
    @(posedge clk); #1;
    @(negedge clk);
    #2;
    resetn = 1'b0; op_valid = 1'b0;
    #1;
    checks++;
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rst_mid_hilo: got %h expected 0", {hi, lo}); end
    checks++;
    if ({stallreq, mul_signed, mul_opa} !== 34'd0) begin
      errors++; $display("FAIL rst_mid_ctrl: got %h expected 0", {stallreq, mul_signed, mul_opa});
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, st);
    exp_hi = 32'd1; exp_lo = 32'hFFFF_FFFE;
    checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++; $display("FAIL rst_then_multu: got %h expected %h", {hi, lo}, {exp_hi, exp_lo});
    end
    checks++;
    if (st !== MUL_LAT || cap_mul_signed !== 1'b0) begin
      errors++; $display("FAIL rst_then_multu_ctrl: got stalls=%0d signed=%b expected %0d,0", st, cap_mul_signed, MUL_LAT);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] r;
    int st, exp_st;
    for (int n = 0; n < 24; n++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom);
      div_lat = $urandom_range(1, 30);
      issue(o, a, b, st);
      exp_st = 0;
      if (o <= OP_DIVU) begin
        r = ref_hilo(o, a, b);
        exp_hi = r[63:32]; exp_lo = r[31:0];
        exp_st = (o <= OP_MULTU) ? MUL_LAT : 1 + div_lat;
        checks++;
        if ({cap_opa, cap_opb} !== {a, b}) begin
          errors++; $display("FAIL rnd_operands op=%0d: got %h expected %h", o, {cap_opa, cap_opb}, {a, b});
        end
        checks++;
        if ((o <= OP_MULTU ? cap_mul_signed : cap_div_signed) !== (o == OP_MULT || o == OP_DIV)) begin
          errors++; $display("FAIL rnd_signed op=%0d: got mul=%b div=%b", o, cap_mul_signed, cap_div_signed);
        end
      end else if (o == OP_MTHI) exp_hi = a;
      else if (o == OP_MTLO) exp_lo = a;
      checks++;
      if (st !== exp_st) begin errors++; $display("FAIL rnd_stall op=%0d: got %0d expected %0d", o, st, exp_st); end
      checks++;
      if ({hi, lo} !== {exp_hi, exp_lo}) begin
        errors++; $display("FAIL rnd_hilo op=%0d a=%h b=%h: got %h expected %h", o, a, b, {hi, lo}, {exp_hi, exp_lo});
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_flush();
    test_mthi_mtlo();
    test_done_hold();
    test_watchdog();
    test_reset_mid_mul();
    test_random_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
